// File: rtl/module_fc_layer.sv
// Dense layer fed by module_max_pool. It buffers IN_LEN int8 samples, then evaluates OUT_NUM
// neurons from external weight and bias ROMs. Define FC_RELU_EN to clamp negative outputs to 0.
module module_fc_layer #(
    parameter int IN_LEN  = 16,
    parameter int OUT_NUM = 4,
    parameter int ACC_W   = 32,
    parameter int SHIFT   = 7,
    localparam int W_AW   = (IN_LEN * OUT_NUM > 1) ? $clog2(IN_LEN * OUT_NUM) : 1,
    localparam int B_AW   = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_in,
    input  logic signed [7:0]      din,
    output logic [W_AW-1:0]        w_addr,
    input  logic signed [7:0]      w_data,
    output logic [B_AW-1:0]        b_addr,
    input  logic signed [15:0]     b_data,
    output logic                   busy,
    output logic                   valid_out,
    output logic signed [7:0]      dout,
    output logic [B_AW-1:0]        dout_idx,
    output logic                   err_overflow
);

    localparam int K_W   = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
    localparam int RND_I = 1 << (SHIFT - 1);

    localparam logic [K_W-1:0]          K_LAST  = K_W'(IN_LEN - 1);
    localparam logic [B_AW-1:0]         N_LAST  = B_AW'(OUT_NUM - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-128);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        DRAIN,
        OUT
    } state_t;

    state_t state_reg, state_next;

    logic signed [7:0]       buf_mem [0:IN_LEN-1];
    logic signed [7:0]       buf_rd_reg;
    logic [K_W-1:0]          k_reg;
    logic [K_W-1:0]          i_reg;
    logic [B_AW-1:0]         n_reg;
    logic [W_AW-1:0]         w_addr_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic                    valid_out_reg;
    logic signed [7:0]       dout_reg;
    logic [B_AW-1:0]         dout_idx_reg;
    logic                    err_reg;

    logic                    accept;
    logic signed [15:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;
    logic signed [7:0]       sat_val;

    assign busy   = (state_reg == COMPUTE) || (state_reg == DRAIN) || (state_reg == OUT);
    assign accept = valid_in && ((state_reg == IDLE) || (state_reg == LOAD));

    // Buffer read is registered: buf[i] lines up with w_data for address i one cycle later.
    assign prod     = buf_rd_reg * w_data;
    assign prod_ext = {{(ACC_W-16){prod[15]}}, prod};
    assign bias_ext = {{(ACC_W-16){b_data[15]}}, b_data};
    assign sum      = acc_reg + bias_ext;
    assign shifted  = (sum + ACC_W'(RND_I)) >>> SHIFT;

    always_comb begin
        sat_val = shifted[7:0];
        if (shifted > SAT_MAX) begin
            sat_val = 8'h7F;
        end else if (shifted < SAT_MIN) begin
            sat_val = 8'h80;
        end
`ifdef FC_RELU_EN
        if (sat_val[7]) begin
            sat_val = 8'h00;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (valid_in) begin
                    state_next = (k_reg == K_LAST) ? COMPUTE : LOAD;
                end
            end
            LOAD: begin
                if (valid_in && (k_reg == K_LAST)) begin
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                if (i_reg == K_LAST) begin
                    state_next = DRAIN;
                end
            end
            DRAIN:   state_next = OUT;
            OUT:     state_next = (n_reg == N_LAST) ? IDLE : COMPUTE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_mem[k_reg] <= din;
        end
        buf_rd_reg <= buf_mem[i_reg];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_reg         <= '0;
            i_reg         <= '0;
            n_reg         <= '0;
            w_addr_reg    <= '0;
            acc_reg       <= '0;
            valid_out_reg <= 1'b0;
            dout_reg      <= '0;
            dout_idx_reg  <= '0;
            err_reg       <= 1'b0;
        end else begin
            valid_out_reg <= 1'b0;
            if (valid_in && busy) begin
                err_reg <= 1'b1;
            end
            case (state_reg)
                IDLE, LOAD: begin
                    if (valid_in) begin
                        if (k_reg == K_LAST) begin
                            k_reg      <= '0;
                            i_reg      <= '0;
                            n_reg      <= '0;
                            w_addr_reg <= '0;
                        end else begin
                            k_reg <= k_reg + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (i_reg == K_LAST) begin
                        i_reg <= '0;
                    end else begin
                        i_reg      <= i_reg + 1'b1;
                        w_addr_reg <= w_addr_reg + 1'b1;
                    end
                    // No product is valid yet on the first address cycle.
                    if (i_reg == '0) begin
                        acc_reg <= '0;
                    end else begin
                        acc_reg <= acc_reg + prod_ext;
                    end
                end
                DRAIN: begin
                    acc_reg <= acc_reg + prod_ext;
                end
                OUT: begin
                    dout_reg      <= sat_val;
                    dout_idx_reg  <= n_reg;
                    valid_out_reg <= 1'b1;
                    if (n_reg != N_LAST) begin
                        n_reg      <= n_reg + 1'b1;
                        i_reg      <= '0;
                        w_addr_reg <= w_addr_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_addr       = w_addr_reg;
    assign b_addr       = n_reg;
    assign valid_out    = valid_out_reg;
    assign dout         = dout_reg;
    assign dout_idx     = dout_idx_reg;
    assign err_overflow = err_reg;

endmodule

// File: doc/module_fc_layer.md
Name: module_fc_layer

Overview:
- Fully connected (dense) stage that sits directly downstream of module_max_pool.
- Collects one vector of IN_LEN signed int8 pooled samples from the pool's valid/din stream into a local buffer.
- Then computes OUT_NUM neuron outputs sequentially, fetching weights and biases from external synchronous ROMs.
- Each output is requantized to signed int8 and emitted with a one-cycle valid pulse and a neuron index.

Parameters:
- IN_LEN, 16, number of int8 inputs per vector; each neuron has IN_LEN weights.
- OUT_NUM, 4, number of neurons computed per vector.
- ACC_W, 32, signed accumulator width; must be ≥ 16+clog2(IN_LEN)+1.
- SHIFT, 7, requantization right-shift amount; must be ≥ 1.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- valid_in  input  1  din carries a valid pooled sample this cycle.
- din  input  8  signed pooled sample (from module_max_pool dout).
- w_addr  output  clog2(IN_LEN*OUT_NUM)  weight ROM address; w_addr = n*IN_LEN + i.
- w_data  input  8  signed weight; returned 1 cycle after w_addr.
- b_addr  output  clog2(OUT_NUM)  bias ROM address = current neuron n.
- b_data  input  16  signed bias; returned 1 cycle after b_addr, stable during a neuron.
- busy  output  1  high in COMPUTE, DRAIN and OUT states.
- valid_out  output  1  one-cycle pulse, dout/dout_idx valid.
- dout  output  8  signed requantized neuron output.
- dout_idx  output  clog2(OUT_NUM)  neuron index of dout.
- err_overflow  output  1  sticky flag: a sample arrived while busy.

Behaviour:
- Reset (rst_n=0 at a clk edge): state→IDLE; all counters, accumulator, w_addr, b_addr, busy, valid_out, dout, dout_idx and err_overflow →0. Input buffer contents are don't-care. Reset wins over every other event, including mid-COMPUTE; a partial vector is discarded and no valid_out follows.
- IDLE/LOAD:
  - Each valid_in beat writes din to buf[k], then k++. Non-consecutive beats are allowed.
  - The first beat moves IDLE→LOAD.
  - The beat that writes buf[IN_LEN-1] resets k=0, n=0, i=0 and moves to COMPUTE on the next edge.
- COMPUTE:
  - Cycle i (0..IN_LEN-1) drives w_addr=n*IN_LEN+i and b_addr=n.
  - On cycle i+1: acc += buf[i]*w_data (signed 8x8 →16, sign-extended to ACC_W).
  - acc is cleared on the cycle w_addr issues i=0.
  - After i=IN_LEN-1, go to DRAIN.
- DRAIN: one cycle; accumulates the last product. Then go to OUT.
- OUT:
  - s = acc + sext(b_data).
  - r = (s + 2^(SHIFT-1)) >>> SHIFT (arithmetic, round-half-up).
  - Saturate r to [-128,127].
  - On the next edge: dout=sat(r), dout_idx=n, valid_out=1 for exactly one cycle.
  - If n<OUT_NUM-1: n++, i=0, back to COMPUTE. Otherwise go to IDLE.
- Timing:
  - Per-neuron period is IN_LEN+2 cycles, issued back-to-back.
  - The first valid_out comes IN_LEN+2 cycles after entering COMPUTE.
  - dout/dout_idx hold their value until the next valid_out.
- valid_in while busy=1: sample dropped, buffer untouched, err_overflow←1. err_overflow clears only on reset.
- A valid_in in the same cycle as the final OUT→IDLE transition is also dropped and flagged. Acceptance resumes the cycle busy is low.
- No backpressure; the upstream stage must space vectors ≥ OUT_NUM*(IN_LEN+2) cycles apart.

Optional Feature:
- Macro FC_RELU_EN.
- Defined: after saturation, negative results are forced to 0, so dout ∈ [0,127].
- Undefined: full signed range [-128,127] is output.
- Latency, handshake and err_overflow behaviour are identical in both builds.

Test Plan:
- IN_LEN=4, OUT_NUM=2, SHIFT=2; din=1,1,1,1; all w=1; b=0 → two valid_out pulses 6 cycles apart, dout=1 (6>>2), dout_idx=0 then 1; busy low after second pulse.
- Same params; din=127×4, w=127, b=0 → acc=64516, dout=127 (saturated); din=-128×4, w=127 → dout=-128, or 0 with FC_RELU_EN.
- Rounding: IN_LEN=4, SHIFT=2; din={1,1,1,0}, w=1, b=-1 → s=2, (2+2)>>2 → dout=1; b=-2 → s=1 → dout=0.
- Overflow: valid_in pulsed during COMPUTE with din=99 → err_overflow=1 and stays 1; outputs unchanged from the no-pulse run; next vector computes correctly.
- Gapped input: 4 samples with 3-cycle gaps → identical dout to the back-to-back run; w_addr sequence 0,1,2,3 then 4,5,6,7.
- Reset mid-COMPUTE: rst_n=0 for 1 cycle at i=2 of neuron 0 → no valid_out, all outputs 0, err_overflow=0; a fresh vector afterwards produces correct results.
